i2c_config_master: RTL and testbench
====================================

Name: i2c_config_master

Overview:
- I2C single-master writer that drives the DDC module's configuration slave from the host-side FPGA.
- On a start strobe it snapshots RX frequency, TX frequency, sample rate and TX level, then sends one write transaction: Start, address byte, 10 data bytes MSB-first, Stop.
- Checks every ACK and reports completion or NACK error to the host control logic.
- Open-drain outputs connect to the board SDA/SCL pads via tri-state buffers at top level.

Parameters:
- i2c_address, 8'hD2, full 8-bit write address (R/W=0) sent as first byte.
- CLK_DIV, 5, clock cycles per quarter SCL period. At 2 MHz this gives 100 kHz SCL. Legal range 2..255.

Ports:
- clock  in  1  system clock, 2 MHz nominal.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle request strobe; ignored while busy=1.
- rx_freq  in  32  receiver frequency, sampled on accepted start.
- tx_freq  in  32  transmitter frequency, sampled on accepted start.
- s_rate  in  8  sample-rate code (0=50k, 1=100k, 2=200k), sampled on start.
- tx_level  in  8  TX drive level 0..255, sampled on start.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- scl_in  in  1  pad SCL, already 2-FF synchronised at top level.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_in  in  1  pad SDA, already synchronised.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transaction (success or error).
- nack_err  out  1  valid with done; held until next accepted start.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, nack_err=0, state=IDLE, tick counter=0, shift/byte/bit counters=0.
- Reset asserted mid-transaction releases both lines on the next clock edge with no Stop generated. Tolerating this is the slave's job, since it resynchronises on the next Start.
- Tick generator: counter counts 0..CLK_DIV-1 and emits a tick on wrap. Every FSM phase advance happens on a tick only.
- Clock stretching: in any phase where scl_oe=0, the tick counter holds at 0 while scl_in=0. Stretch time is unbounded (no timeout).
- Start acceptance: start=1 while IDLE latches {rx_freq, tx_freq, s_rate, tx_level} into an 80-bit snapshot, sets busy=1, clears nack_err. Input changes during the transaction have no effect. start while busy is dropped, not queued.
- Byte order: address, RXF[31:24], RXF[23:16], RXF[15:8], RXF[7:0], TXF[31:24] .. TXF[7:0], s_rate, tx_level. Each byte MSB-first.
- FSM states and transitions:
  - IDLE -> START0 on accepted start.
  - START0 (SDA released, SCL released) -> START1, which pulls SDA low with SCL high for 1 tick.
  - START1 -> START2, which pulls SCL low.
  - START2 -> BIT.
  - BIT, 4 ticks per bit. q0: set sda_oe = ~bit with SCL low. q1: release SCL. q2: hold SCL high. q3: pull SCL low. After bit 7 -> ACK.
  - ACK, 4 ticks. q0: release SDA. q1: release SCL. q2: sample sda_in at the end of the high phase, 0 = ACK. q3: pull SCL low.
  - ACK leads to BIT for the next byte if ACK and byte_cnt<10. It leads to STOP0 if ACK and the last byte is sent, or on NACK (nack_err=1).
  - STOP0: SDA low, SCL low -> STOP1: release SCL -> STOP2: release SDA with SCL high -> DONE.
  - DONE: done=1 for one clock, busy=0 -> IDLE.
- Bus-level guarantees:
  - SDA changes only while SCL is low, except the Start/Stop edges.
  - Stop gives SCL high then SDA rising with at least one tick between them. This satisfies the slave's stop detector.
- Timing: successful transaction = 3 + 11*9*4 + 3 ticks = 402 ticks, plus 1 clock for DONE. At CLK_DIV=5 with no stretching, done arrives 2011 clocks after start (+/-1 for tick phase alignment; the tick counter is restarted on accept so this is exact).
- NACK on the address byte sends Stop immediately after the first ACK slot (39 ticks). No data bytes go out.
- Simultaneous start and done cycle: start is ignored because busy is still 1 in that cycle.

Decomposition:
- Package i2c_cfg_pkg holds:
  - FSM state encodings.
  - NUM_DATA_BYTES=10.
  - Default address 8'hD2.
  - Sample-rate code constants SR_50K=0, SR_100K=1, SR_200K=2.
- Sub-module i2c_tick_gen (CLK_DIV, stretch hold input) produces the quarter-period tick.

Test Plan:
- Write all fields: rx_freq=32'h006ACFC0, tx_freq=32'h006B0C80, s_rate=2, tx_level=8'hC8, behavioural slave ACKs everything. Required bytes on the bus: D2 00 6A CF C0 00 6B 0C 80 02 C8. done at clock 2011, nack_err=0. Connected to the real slave, its outputs must match.
- Address NACK (slave at 8'hD4): only byte D2 appears, then Stop. done with nack_err=1. Data bytes never clocked.
- NACK on the 6th byte: Stop follows that ACK slot, nack_err=1. A new start clears nack_err and the transaction completes cleanly.
- Clock stretching: slave holds SCL low for 37 clocks after byte 3's ACK. Bit timing resumes correctly and done is delayed by exactly 37 clocks.
- start pulsed again at clock 500 with changed inputs: ignored, and the bus data matches the first snapshot.
- Reset deasserted-to-asserted at clock 1000: next cycle scl_oe=0, sda_oe=0, busy=0. A following start produces a full correct transaction.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cfg_pkg
// Description : Shared definitions for the DDC configuration I2C master:
//               FSM state encoding, payload size, default slave address and
//               sample-rate code values.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

    // Data bytes that follow the address byte in every write transaction.
    localparam int NUM_DATA_BYTES = 10;

    // Full 8-bit write address, R/W bit already 0.
    localparam logic [7:0] DEFAULT_I2C_ADDRESS = 8'hD2;

    // Sample-rate codes understood by the DDC slave.
    localparam logic [7:0] SR_50K  = 8'd0;
    localparam logic [7:0] SR_100K = 8'd1;
    localparam logic [7:0] SR_200K = 8'd2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START0 = 4'd1,
        ST_START1 = 4'd2,
        ST_START2 = 4'd3,
        ST_BIT    = 4'd4,
        ST_ACK    = 4'd5,
        ST_STOP0  = 4'd6,
        ST_STOP1  = 4'd7,
        ST_STOP2  = 4'd8,
        ST_DONE   = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tick_gen
// Description : Quarter-SCL-period tick generator. Counts 0..CLK_DIV-1 and
//               emits a one-clock tick on the wrap cycle.
// Ports       : clock, reset (sync, active-low)
//               i_clear - restart the count at 0 (transaction accept)
//               i_hold  - hold the count at 0 (slave clock stretching)
//               o_tick  - one-cycle quarter-period tick
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tick_gen
    import i2c_cfg_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);

    localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (i_clear || i_hold) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Suppressed while cleared or held so a stretched phase never advances.
    assign o_tick = (r_cnt == c_LAST) && !i_clear && !i_hold;

endmodule
`default_nettype wire

// File: rtl/i2c_config_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_config_master
// Description : Single-master I2C writer for the DDC configuration slave.
//               On an accepted start it snapshots the configuration and
//               sends Start, address, 10 data bytes (MSB first), Stop,
//               checking every ACK.
// Ports       : clock, reset (sync, active-low)
//               start                 - request strobe, ignored while busy
//               rx_freq, tx_freq      - 32-bit frequencies
//               s_rate, tx_level      - 8-bit sample-rate code / TX level
//               scl_oe / sda_oe       - 1 = pull line low (open drain)
//               scl_in / sda_in       - synchronised pad levels
//               busy, done, nack_err  - status to host control logic
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_config_master
    import i2c_cfg_pkg::*;
#(
    parameter logic [7:0] I2C_ADDRESS = DEFAULT_I2C_ADDRESS,
    parameter int         CLK_DIV     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rx_freq,
    input  logic [31:0] tx_freq,
    input  logic [7:0]  s_rate,
    input  logic [7:0]  tx_level,
    output logic        scl_oe,
    input  logic        scl_in,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic        busy,
    output logic        done,
    output logic        nack_err
);

    localparam logic [3:0] c_LAST_BYTE = 4'(NUM_DATA_BYTES);

    state_t      r_state;
    logic [79:0] r_snap;       // remaining data bytes, next one in [79:72]
    logic [7:0]  r_byte;       // byte being shifted out, current bit in [7]
    logic [3:0]  r_byte_cnt;   // data bytes loaded so far
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_quarter;
    logic        r_scl_oe;
    logic        r_sda_oe;
    logic        r_busy;
    logic        r_done;
    logic        r_nack_err;
    logic        r_nack_seen;

    logic        w_accept;
    logic        w_hold;
    logic        w_tick;

    // busy stays high through the done cycle, so a start there is dropped.
    assign w_accept = (r_state == ST_IDLE) && !r_busy && start;
    // A released SCL that still reads low means the slave is stretching.
    assign w_hold   = !r_scl_oe && !scl_in;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_accept),
        .i_hold  (w_hold),
        .o_tick  (w_tick)
    );

    // Each phase's line levels are set on the tick that enters it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_snap      <= '0;
            r_byte      <= '0;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_quarter   <= '0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack_err  <= 1'b0;
            r_nack_seen <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_busy      <= 1'b1;
                        r_nack_err  <= 1'b0;
                        r_nack_seen <= 1'b0;
                        r_snap      <= {rx_freq, tx_freq, s_rate, tx_level};
                        r_byte      <= I2C_ADDRESS;
                        r_byte_cnt  <= '0;
                        r_bit_cnt   <= '0;
                        r_quarter   <= '0;
                        r_state     <= ST_START0;
                    end
                end
                ST_START0: if (w_tick) begin
                    r_sda_oe <= 1'b1;              // Start: SDA falls, SCL high
                    r_state  <= ST_START1;
                end
                ST_START1: if (w_tick) begin
                    r_scl_oe <= 1'b1;
                    r_state  <= ST_START2;
                end
                ST_START2: if (w_tick) begin
                    r_sda_oe  <= ~r_byte[7];
                    r_bit_cnt <= '0;
                    r_quarter <= '0;
                    r_state   <= ST_BIT;
                end
                ST_BIT: if (w_tick) begin
                    case (r_quarter)
                        2'd0: begin
                            r_scl_oe  <= 1'b0;
                            r_quarter <= 2'd1;
                        end
                        2'd1: r_quarter <= 2'd2;
                        2'd2: begin
                            r_scl_oe  <= 1'b1;
                            r_quarter <= 2'd3;
                        end
                        default: begin
                            r_quarter <= 2'd0;
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_oe <= 1'b0;  // hand SDA to the slave
                                r_state  <= ST_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_byte    <= {r_byte[6:0], 1'b0};
                                r_sda_oe  <= ~r_byte[6];
                            end
                        end
                    endcase
                end
                ST_ACK: if (w_tick) begin
                    case (r_quarter)
                        2'd0: begin
                            r_scl_oe  <= 1'b0;
                            r_quarter <= 2'd1;
                        end
                        2'd1: r_quarter <= 2'd2;
                        2'd2: begin
                            r_nack_seen <= sda_in;  // end of SCL high phase
                            r_scl_oe    <= 1'b1;
                            r_quarter   <= 2'd3;
                        end
                        default: begin
                            r_quarter <= 2'd0;
                            if (r_nack_seen || (r_byte_cnt == c_LAST_BYTE)) begin
                                r_sda_oe <= 1'b1;
                                r_state  <= ST_STOP0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 4'd1;
                                r_byte     <= r_snap[79:72];
                                r_snap     <= {r_snap[71:0], 8'h00};
                                r_sda_oe   <= ~r_snap[79];
                                r_bit_cnt  <= '0;
                                r_state    <= ST_BIT;
                            end
                        end
                    endcase
                end
                ST_STOP0: if (w_tick) begin
                    r_scl_oe <= 1'b0;
                    r_state  <= ST_STOP1;
                end
                ST_STOP1: if (w_tick) begin
                    r_sda_oe <= 1'b0;              // Stop: SDA rises, SCL high
                    r_state  <= ST_STOP2;
                end
                ST_STOP2: if (w_tick) begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_nack_err <= r_nack_seen;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign scl_oe   = r_scl_oe;
    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign nack_err = r_nack_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_config_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_config_master
// Description : Self-checking bench for i2c_config_master with a
//               behavioural I2C slave (ACK/NACK, clock stretching) and a
//               transaction-level model of status timing and bus bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_config_master;
    import i2c_cfg_pkg::*;

    localparam int CLK_DIV = 5;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] rx_freq  = '0;
    logic [31:0] tx_freq  = '0;
    logic [7:0]  s_rate   = '0;
    logic [7:0]  tx_level = '0;
    logic        scl_oe, sda_oe, busy, done, nack_err;
    logic        scl_in, sda_in;
    logic        slave_scl_low = 1'b0;
    logic        slave_sda_low = 1'b0;

    // Open-drain bus with pull-ups.
    assign scl_in = ~scl_oe & ~slave_scl_low;
    assign sda_in = ~sda_oe & ~slave_sda_low;

    i2c_config_master #(
        .I2C_ADDRESS (8'hD2),
        .CLK_DIV     (CLK_DIV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rx_freq  (rx_freq),
        .tx_freq  (tx_freq),
        .s_rate   (s_rate),
        .tx_level (tx_level),
        .scl_oe   (scl_oe),
        .scl_in   (scl_in),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in),
        .busy     (busy),
        .done     (done),
        .nack_err (nack_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model of status outputs: accept edge, done edge, expected nack flag.
    int t_accept  = -1;
    int t_done    = -1;
    bit exp_nack  = 1'b0;
    bit prev_nack = 1'b0;
    bit cmp_en    = 1'b0;
    bit mon_en    = 1'b0;

    // Slave configuration and observed bus activity.
    logic [7:0] slave_addr   = 8'hD2;
    int         nack_at      = -1;
    int         stretch_byte = -1;
    int         stretch_len  = 0;
    bit         stretch_active = 1'b0;
    int         held         = 0;
    logic [7:0] obs_q [$];
    int         starts = 0;
    int         stops  = 0;
    logic [7:0] sr     = '0;
    int         bitcnt = 0;
    int         byte_idx = 0;
    bit         in_ack = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Per-cycle status compare against the transaction model.
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            bit eb, ed, en;
            logic [4:0] act, exp;
            eb = (t_accept >= 0) && (cyc >= t_accept) && (cyc <= t_done);
            ed = (t_done >= 0) && (cyc == t_done);
            if (t_accept < 0)      en = 1'b0;
            else if (cyc < t_accept) en = prev_nack;
            else if (cyc < t_done)   en = 1'b0;
            else                     en = exp_nack;
            act = {busy, done, nack_err, eb ? 1'b0 : scl_oe, eb ? 1'b0 : sda_oe};
            exp = {eb, ed, en, 2'b00};
            chk("status{busy,done,nack_err,idle_scl_oe,idle_sda_oe}", 64'(act), 64'(exp));
        end
    end

    // Behavioural slave: decodes Start/Stop/bytes, drives ACK, stretches SCL.
    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            logic s, d;
            s = scl_in;
            d = sda_in;
            if (s && prev_scl && prev_sda && !d) begin
                starts++;
                bitcnt   = 0;
                byte_idx = 0;
                in_ack   = 1'b0;
                obs_q.delete();
            end else if (s && prev_scl && !prev_sda && d) begin
                stops++;
            end else if (s && !prev_scl) begin
                if (!in_ack) begin
                    sr = {sr[6:0], d};
                    bitcnt++;
                    if (bitcnt == 8) obs_q.push_back(sr);
                end
            end else if (!s && prev_scl) begin
                if (in_ack) begin
                    in_ack        = 1'b0;
                    slave_sda_low = 1'b0;
                    bitcnt        = 0;
                    if (byte_idx == stretch_byte) begin
                        stretch_active = 1'b1;
                        slave_scl_low  = 1'b1;
                        held           = 0;
                    end
                    byte_idx++;
                end else if (bitcnt == 8) begin
                    in_ack        = 1'b1;
                    slave_sda_low = ((byte_idx != 0) || (sr == slave_addr)) && (byte_idx != nack_at);
                end
            end
            if (stretch_active && !scl_oe) begin
                if (held == stretch_len) begin
                    stretch_active = 1'b0;
                    slave_scl_low  = 1'b0;
                end else begin
                    held++;
                end
            end
            prev_scl = s;
            prev_sda = d;
        end
    end

    task automatic run_txn(input logic [31:0] rx, input logic [31:0] tx,
                           input logic [7:0] sr_i, input logic [7:0] lvl,
                           input logic [7:0] saddr, input int nack_i,
                           input int sbyte, input int slen, input int restart_at,
                           output int lat);
        logic [7:0] eb [11];
        int nidx, n, dclk;
        eb[0] = 8'hD2;
        for (int i = 0; i < 4; i++) begin
            eb[1 + i] = 8'(rx >> (24 - 8 * i));
            eb[5 + i] = 8'(tx >> (24 - 8 * i));
        end
        eb[9]  = sr_i;
        eb[10] = lvl;
        nidx = (saddr != 8'hD2) ? 0 : ((nack_i >= 0 && nack_i <= 10) ? nack_i : -1);
        n    = (nidx >= 0) ? nidx + 1 : 11;
        // 3 start ticks + 36 per byte + 3 stop ticks, then one DONE clock.
        dclk = (6 + 36 * n) * CLK_DIV + 1 + ((sbyte >= 0 && sbyte < n) ? slen : 0);

        slave_addr   = saddr;
        nack_at      = nack_i;
        stretch_byte = sbyte;
        stretch_len  = slen;
        starts = 0;
        stops  = 0;
        obs_q.delete();

        rx_freq  = rx;
        tx_freq  = tx;
        s_rate   = sr_i;
        tx_level = lvl;
        start    = 1'b1;
        prev_nack = exp_nack;
        exp_nack  = (nidx >= 0);
        t_accept  = cyc + 1;
        t_done    = t_accept + dclk;
        step();
        start    = 1'b0;
        rx_freq  = $urandom;
        tx_freq  = $urandom;
        s_rate   = 8'($urandom);
        tx_level = 8'($urandom);
        if (restart_at > 0) begin
            while (cyc < t_accept + restart_at) step();
            start    = 1'b1;
            rx_freq  = $urandom;
            tx_freq  = $urandom;
            s_rate   = 8'($urandom);
            tx_level = 8'($urandom);
            step();
            start = 1'b0;
        end
        lat = -1;
        for (int k = 0; k < dclk + 100; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                lat = cyc - t_accept;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: none within %0d cycles, required latency %0d", dclk + 100, dclk);
        end else begin
            chk("done_latency", 64'(lat), 64'(dclk));
        end
        repeat (3) step();
        chk("byte_count", 64'(obs_q.size()), 64'(n));
        chk("start_count", 64'(starts), 64'd1);
        chk("stop_count", 64'(stops), 64'd1);
        for (int i = 0; i < n && i < obs_q.size(); i++)
            chk($sformatf("bus_byte[%0d]", i), 64'(obs_q[i]), 64'(eb[i]));
        stretch_byte = -1;
    endtask

    initial begin
        logic [7:0] lit [11];
        int lat;
        int r, nk, sb;
        lit = '{8'hD2, 8'h00, 8'h6A, 8'hCF, 8'hC0, 8'h00, 8'h6B, 8'h0C, 8'h80, 8'h02, 8'hC8};

        reset = 1'b0;
        repeat (3) step();
        chk("reset_scl_oe", 64'(scl_oe), 64'd0);
        chk("reset_sda_oe", 64'(sda_oe), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_nack_err", 64'(nack_err), 64'd0);
        mon_en = 1'b1;
        cmp_en = 1'b1;
        reset  = 1'b1;
        repeat (4) step();

        // Full write, slave ACKs everything.
        run_txn(32'h006ACFC0, 32'h006B0C80, SR_200K, 8'hC8, 8'hD2, -1, -1, 0, 0, lat);
        chk("full_latency_literal", 64'(lat), 64'd2011);
        for (int i = 0; i < 11 && i < obs_q.size(); i++)
            chk($sformatf("literal_byte[%0d]", i), 64'(obs_q[i]), 64'(lit[i]));
        chk("full_nack_err", 64'(nack_err), 64'd0);

        // Address NACK: slave answers at D4.
        run_txn($urandom, $urandom, SR_50K, 8'h11, 8'hD4, -1, -1, 0, 0, lat);
        chk("addr_nack_latency_literal", 64'(lat), 64'd211);
        chk("addr_nack_bytes_literal", 64'(obs_q.size()), 64'd1);
        chk("addr_nack_err", 64'(nack_err), 64'd1);

        // NACK on the 6th byte, then a clean transaction clears nack_err.
        run_txn($urandom, $urandom, SR_100K, 8'h55, 8'hD2, 5, -1, 0, 0, lat);
        chk("byte6_nack_err", 64'(nack_err), 64'd1);
        run_txn($urandom, $urandom, SR_200K, 8'hAA, 8'hD2, -1, -1, 0, 0, lat);
        chk("clean_after_nack_err", 64'(nack_err), 64'd0);

        // Slave stretches SCL 37 clocks after byte 3's ACK.
        run_txn(32'h12345678, 32'h9ABCDEF0, SR_100K, 8'h7F, 8'hD2, -1, 3, 37, 0, lat);
        chk("stretch_latency_literal", 64'(lat), 64'd2048);

        // Second start at clock 500 with changed inputs is dropped.
        run_txn(32'hCAFEF00D, 32'h0BADBEEF, SR_50K, 8'h33, 8'hD2, -1, -1, 0, 500, lat);

        // Reset 1000 clocks into a transaction.
        rx_freq = $urandom;
        tx_freq = $urandom;
        start   = 1'b1;
        prev_nack = exp_nack;
        exp_nack  = 1'b0;
        t_accept  = cyc + 1;
        t_done    = t_accept + 2011;
        step();
        start = 1'b0;
        while (cyc < t_accept + 999) step();
        reset = 1'b0;
        step();
        t_accept  = -1;
        t_done    = -1;
        exp_nack  = 1'b0;
        prev_nack = 1'b0;
        slave_sda_low  = 1'b0;
        slave_scl_low  = 1'b0;
        stretch_active = 1'b0;
        in_ack = 1'b0;
        bitcnt = 0;
        chk("midreset_scl_oe", 64'(scl_oe), 64'd0);
        chk("midreset_sda_oe", 64'(sda_oe), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (3) step();
        run_txn($urandom, $urandom, SR_200K, 8'hE1, 8'hD2, -1, -1, 0, 0, lat);
        chk("post_reset_latency", 64'(lat), 64'd2011);

        // Randomised transactions.
        for (int t = 0; t < 6; t++) begin
            r  = int'($urandom_range(0, 15));
            nk = (r <= 10) ? r : -1;
            sb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_txn($urandom, $urandom, 8'($urandom_range(0, 2)), 8'($urandom),
                    8'hD2, nk, sb, int'($urandom_range(1, 60)), 0, lat);
            repeat (int'($urandom_range(0, 7))) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
